// File: rtl/decode_hazard_controller.sv
// Decode->execute pipeline register sequencing: load-use bubbles, multi-cycle
// multiply holds, D-cache miss waits and taken-branch flushes.
module decode_hazard_controller #(
    parameter int REGISTER_INDEX_WIDTH = 5,
    parameter int MUL_LATENCY          = 5,
    parameter int FLUSH_CYCLES         = 2,
    parameter int CNT_WIDTH            = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            id_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0] id_src1,
    input  logic [REGISTER_INDEX_WIDTH-1:0] id_src2,
    input  logic                            id_uses_src2,
    input  logic                            id_is_mul,
    input  logic [REGISTER_INDEX_WIDTH-1:0] ex_dst,
    input  logic                            ex_mem_to_reg,
    input  logic                            ex_branch_taken,
    input  logic                            dcache_access,
    input  logic                            dcache_ready,
    output logic                            stall_out,
    output logic                            execution_empty_out,
    output logic                            set_nop_out,
    output logic [15:0]                     stall_count_out
);

    typedef enum logic [1:0] {RUN, MUL_BUSY, MEM_WAIT, FLUSH} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MUL_LOAD   = CNT_WIDTH'(MUL_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD = CNT_WIDTH'(FLUSH_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [15:0]          stall_count_q, stall_count_d;

    logic                 load_use;
    logic                 run_like;
    logic [CNT_WIDTH-1:0] cnt_dec;

    assign load_use = ex_mem_to_reg & id_valid & (ex_dst != '0) &
                      ((ex_dst == id_src1) | (id_uses_src2 & (ex_dst == id_src2)));
    assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        stall_out           = 1'b0;
        execution_empty_out = 1'b1;
        set_nop_out         = 1'b0;
        run_like            = 1'b0;

        if (!reset) begin
            stall_out   = 1'b1;
            set_nop_out = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
        end else if (ex_branch_taken) begin
            // A single-bubble flush is fully covered by the branch cycle itself.
            set_nop_out = 1'b1;
            state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_d       = FLUSH_LOAD;
        end else begin
            case (state_q)
                MUL_BUSY: begin
                    stall_out           = 1'b1;
                    execution_empty_out = 1'b0;
                    cnt_d               = cnt_dec;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                MEM_WAIT: begin
                    if (dcache_ready) begin
                        run_like = 1'b1;
                    end else begin
                        stall_out           = 1'b1;
                        execution_empty_out = 1'b0;
                    end
                end
                FLUSH: begin
                    set_nop_out = 1'b1;
                    cnt_d       = cnt_dec;
                    // Branch cycle already supplied one bubble, so exit as the count drains.
                    if (cnt_q <= CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                default: run_like = 1'b1;
            endcase
        end

        if (run_like) begin
            state_d = RUN;
            if (load_use) begin
                stall_out   = 1'b1;
                set_nop_out = 1'b1;
            end else if (id_is_mul && id_valid) begin
                state_d = MUL_BUSY;
                cnt_d   = MUL_LOAD;
            end else if (dcache_access && !dcache_ready) begin
                state_d = MEM_WAIT;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_out && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count_out = stall_count_q;

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Scoreboard bench for decode_hazard_controller: expected {stall, empty, nop}
// is queued as each cycle's stimulus is driven and checked on the falling edge.
module tb_decode_hazard_controller;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_src1;
    logic [4:0] id_src2;
    logic       id_uses_src2;
    logic       id_is_mul;
    logic [4:0] ex_dst;
    logic       ex_mem_to_reg;
    logic       ex_branch_taken;
    logic       dcache_access;
    logic       dcache_ready;
    logic       stall_out;
    logic       execution_empty_out;
    logic       set_nop_out;
    logic [15:0] stall_count_out;

    // Expected control patterns as {stall, execution_empty, set_nop}
    localparam logic [2:0] E_RUN   = 3'b010;
    localparam logic [2:0] E_BUB   = 3'b111;
    localparam logic [2:0] E_HOLD  = 3'b100;
    localparam logic [2:0] E_FLUSH = 3'b011;
    localparam logic [2:0] E_RST   = 3'b111;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    logic [2:0] exp_q[$];
    string      tag_q[$];

    decode_hazard_controller #(
        .REGISTER_INDEX_WIDTH(5),
        .MUL_LATENCY(5),
        .FLUSH_CYCLES(2),
        .CNT_WIDTH(3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .id_valid            (id_valid),
        .id_src1             (id_src1),
        .id_src2             (id_src2),
        .id_uses_src2        (id_uses_src2),
        .id_is_mul           (id_is_mul),
        .ex_dst              (ex_dst),
        .ex_mem_to_reg       (ex_mem_to_reg),
        .ex_branch_taken     (ex_branch_taken),
        .dcache_access       (dcache_access),
        .dcache_ready        (dcache_ready),
        .stall_out           (stall_out),
        .execution_empty_out (execution_empty_out),
        .set_nop_out         (set_nop_out),
        .stall_count_out     (stall_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [2:0] e;
            string      t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val(t, {29'd0, stall_out, execution_empty_out, set_nop_out}, {29'd0, e});
            $display("[TB] %-10s stall=%0b empty=%0b nop=%0b cnt=%0d", t,
                     stall_out, execution_empty_out, set_nop_out, stall_count_out);
        end
    end

    task automatic idle();
        reset           = 1'b1;
        id_valid        = 1'b0;
        id_src1         = '0;
        id_src2         = '0;
        id_uses_src2    = 1'b0;
        id_is_mul       = 1'b0;
        ex_dst          = '0;
        ex_mem_to_reg   = 1'b0;
        ex_branch_taken = 1'b0;
        dcache_access   = 1'b0;
        dcache_ready    = 1'b1;
    endtask

    task automatic load_use_inputs(input logic [4:0] r);
        id_valid      = 1'b1;
        id_src1       = r;
        ex_dst        = r;
        ex_mem_to_reg = 1'b1;
    endtask

    // One cycle: queue the expectation for the current inputs, then advance past the edge.
    task automatic tick(input string tag, input logic [2:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        if (!reset) exp_cnt = 0;
        else if (exp[2] && exp_cnt < 65535) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset behaviour
        for (int i = 0; i < 3; i++) tick("reset", E_RST);
        idle();
        tick("rst_rel", E_RUN);
        check_val("cnt_rst", {16'd0, stall_count_out}, 32'd0);

        // Load-use on src1, src2, and non-hazard variants
        load_use_inputs(5'd5);
        tick("lu_src1", E_BUB);
        idle();
        tick("lu_after", E_RUN);
        id_valid = 1'b1; id_src1 = 5'd3; id_src2 = 5'd7; id_uses_src2 = 1'b1;
        ex_dst = 5'd7; ex_mem_to_reg = 1'b1;
        tick("lu_src2", E_BUB);
        id_uses_src2 = 1'b0;
        tick("lu_nouse", E_RUN);
        idle();
        load_use_inputs(5'd0);
        tick("lu_r0", E_RUN);
        load_use_inputs(5'd9);
        id_valid = 1'b0;
        tick("lu_inval", E_RUN);
        load_use_inputs(5'd9);
        ex_mem_to_reg = 1'b0;
        tick("lu_noload", E_RUN);
        check_val("cnt_lu", {16'd0, stall_count_out}, exp_cnt);

        // Multiply: 4 busy cycles, load-use ignored while busy
        idle();
        id_valid = 1'b1; id_is_mul = 1'b1;
        tick("mul_iss", E_RUN);
        idle();
        load_use_inputs(5'd4);
        for (int i = 0; i < 4; i++) tick("mul_busy", E_HOLD);
        idle();
        tick("mul_done", E_RUN);
        check_val("cnt_mul", {16'd0, stall_count_out}, exp_cnt);

        // D-cache miss: 7 wait cycles, ready cycle acts as RUN (load-use bubble)
        idle();
        dcache_access = 1'b1; dcache_ready = 1'b0;
        tick("mem_det", E_RUN);
        for (int i = 0; i < 7; i++) tick("mem_wait", E_HOLD);
        dcache_ready = 1'b1;
        load_use_inputs(5'd6);
        tick("mem_rdy", E_BUB);
        idle();
        tick("mem_after", E_RUN);
        check_val("cnt_mem", {16'd0, stall_count_out}, exp_cnt);

        // Branch beats load-use; two bubbles total
        load_use_inputs(5'd2);
        ex_branch_taken = 1'b1;
        tick("br_lu", E_FLUSH);
        idle();
        tick("flush", E_FLUSH);
        tick("br_done", E_RUN);

        // Branch interrupts multiply
        id_valid = 1'b1; id_is_mul = 1'b1;
        tick("mul_iss2", E_RUN);
        idle();
        tick("mul_busy2", E_HOLD);
        ex_branch_taken = 1'b1;
        tick("br_mul", E_FLUSH);
        idle();
        tick("flush2", E_FLUSH);
        tick("run2", E_RUN);

        // Branch in FLUSH reloads counter
        ex_branch_taken = 1'b1;
        tick("br_a", E_FLUSH);
        tick("br_b", E_FLUSH);
        idle();
        tick("flush3", E_FLUSH);
        tick("run3", E_RUN);
        check_val("cnt_br", {16'd0, stall_count_out}, exp_cnt);

        // Saturation via a long D-cache miss
        dcache_access = 1'b1; dcache_ready = 1'b0;
        tick("sat_det", E_RUN);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
        end
        exp_cnt = 65535;
        check_val("cnt_sat", {16'd0, stall_count_out}, 32'h0000_FFFF);
        tick("sat_hold", E_HOLD);
        dcache_ready = 1'b1;
        tick("sat_rdy", E_RUN);
        check_val("cnt_sat2", {16'd0, stall_count_out}, 32'h0000_FFFF);

        // Reset during FLUSH and during MUL_BUSY aborts to RUN
        idle();
        ex_branch_taken = 1'b1;
        tick("br_rst", E_FLUSH);
        idle();
        reset = 1'b0;
        tick("rst_fl", E_RST);
        idle();
        tick("rst_fl_run", E_RUN);
        check_val("cnt_rst2", {16'd0, stall_count_out}, 32'd0);
        id_valid = 1'b1; id_is_mul = 1'b1;
        tick("mul_iss3", E_RUN);
        idle();
        tick("mul_busy3", E_HOLD);
        reset = 1'b0;
        tick("rst_mul", E_RST);
        idle();
        tick("rst_mul_run", E_RUN);
        tick("run4", E_RUN);

        @(negedge clk);
        #1;
        check_val("sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
